mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data requesters, data first.
// Access: mem_en one cycle after grant; ready MEM_LAT+1 cycles later; stall_pipe holds the pipeline while unserved.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_pipe
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               owner_d;
    logic               i_done;
    logic               d_done;
    logic               pending_i;
    logic               pending_d;

    assign pending_i  = if_req & ~i_done;
    assign pending_d  = d_req & ~d_done;
    assign stall_pipe = pending_i | pending_d;
    assign if_ready   = i_done;
    assign d_ready    = d_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // A pipeline advance releases both requesters; a completion below overrides this.
            if (!stall_pipe) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (stall_pipe) begin
                        owner_d   <= pending_d;
                        mem_addr  <= pending_d ? d_addr : if_addr;
                        mem_we    <= pending_d & d_we;
                        mem_wdata <= d_wdata;
                        mem_en    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    cnt    <= CNT_W'(MEM_LAT - 1);
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (owner_d) begin
                            d_done <= 1'b1;
                            if (!mem_we) d_rdata <= mem_rdata;
                        end else begin
                            i_done   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
